// File: rtl/memory_game_pkg.sv
// Shared types and defaults for the memory-game pair controller.
package memory_game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_WAIT_FIRST  = 3'd1,
        ST_WAIT_SECOND = 3'd2,
        ST_COMPARE     = 3'd3,
        ST_SHOW        = 3'd4,
        ST_DONE        = 3'd5
    } state_e;

    localparam int N_CARDS_DEF    = 16;
    localparam int SYM_W_DEF      = 3;
    localparam int HIDE_DELAY_DEF = 65_000_000;
    localparam int MOVES_W        = 12;

    // Width of an index/counter able to hold values 0..n-1, never less than 1.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/card_pair_controller_click_encoder.sv
// Turns per-card click levels into one click per cycle: rising-edge detect,
// lowest index wins, and clicks on face-up or matched cards are rejected.
module click_encoder
    import memory_game_pkg::*;
#(
    parameter int N_CARDS = N_CARDS_DEF,
    parameter int IDX_W   = idx_width(N_CARDS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_CARDS-1:0] card_event,
    input  logic [N_CARDS-1:0] block_mask,
    output logic               click_valid,
    output logic [IDX_W-1:0]   click_idx
);

    logic [N_CARDS-1:0] card_event_q;
    logic [N_CARDS-1:0] card_event_d;
    logic [N_CARDS-1:0] rise;
    logic               hit;
    logic [IDX_W-1:0]   idx;

    always_comb begin
        card_event_d = card_event;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            card_event_q <= '0;
        end else begin
            card_event_q <= card_event_d;
        end
    end

    // Scan downward so the lowest rising index is the last one written.
    always_comb begin
        rise = card_event & ~card_event_q;
        hit  = 1'b0;
        idx  = '0;
        for (int i = N_CARDS - 1; i >= 0; i--) begin
            if (rise[i]) begin
                hit = 1'b1;
                idx = IDX_W'(i);
            end
        end
        click_valid = hit && !block_mask[idx];
        click_idx   = idx;
    end

endmodule

// File: rtl/card_pair_controller.sv
// Memory-game logic: flip two cards, compare symbols, keep matched pairs,
// hide mismatches after HIDE_DELAY cycles; counts moves and flags the win.
module card_pair_controller
    import memory_game_pkg::*;
#(
    parameter int N_CARDS    = N_CARDS_DEF,
    parameter int SYM_W      = SYM_W_DEF,
    parameter int HIDE_DELAY = HIDE_DELAY_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [N_CARDS-1:0]         card_event,
    input  logic [N_CARDS*SYM_W-1:0]   card_symbols,
    output logic [N_CARDS-1:0]         revealed,
    output logic [N_CARDS-1:0]         matched,
    output logic [MOVES_W-1:0]         moves,
    output logic                       busy,
    output logic                       game_won
);

    localparam int IDX_W = idx_width(N_CARDS);
    localparam int CNT_W = idx_width(HIDE_DELAY);

    state_e             state_q, state_d;
    logic [N_CARDS-1:0] revealed_q, revealed_d;
    logic [N_CARDS-1:0] matched_q, matched_d;
    logic [MOVES_W-1:0] moves_q, moves_d;
    logic               busy_q, busy_d;
    logic               game_won_q, game_won_d;
    logic [IDX_W-1:0]   first_idx_q, first_idx_d;
    logic [IDX_W-1:0]   second_idx_q, second_idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               click_valid;
    logic [IDX_W-1:0]   click_idx;
    logic [SYM_W-1:0]   sym_arr [N_CARDS];
    logic [N_CARDS-1:0] pair_mask;
    logic [MOVES_W-1:0] moves_inc;

    click_encoder #(
        .N_CARDS (N_CARDS),
        .IDX_W   (IDX_W)
    ) u_click_encoder (
        .clk         (clk),
        .rst         (rst),
        .card_event  (card_event),
        .block_mask  (revealed_q | matched_q),
        .click_valid (click_valid),
        .click_idx   (click_idx)
    );

    for (genvar g = 0; g < N_CARDS; g++) begin : g_sym
        assign sym_arr[g] = card_symbols[g*SYM_W +: SYM_W];
    end

    always_comb begin
        pair_mask               = '0;
        pair_mask[first_idx_q]  = 1'b1;
        pair_mask[second_idx_q] = 1'b1;
        moves_inc = (moves_q == {MOVES_W{1'b1}}) ? moves_q : moves_q + 1'b1;
    end

    always_comb begin
        state_d      = state_q;
        revealed_d   = revealed_q;
        matched_d    = matched_q;
        moves_d      = moves_q;
        first_idx_d  = first_idx_q;
        second_idx_d = second_idx_q;
        cnt_d        = cnt_q;

        case (state_q)
            ST_IDLE: begin
                revealed_d = '0;
                matched_d  = '0;
                moves_d    = '0;
                if (start) begin
                    state_d = ST_WAIT_FIRST;
                end
            end
            ST_WAIT_FIRST: begin
                if (click_valid) begin
                    revealed_d[click_idx] = 1'b1;
                    first_idx_d           = click_idx;
                    state_d               = ST_WAIT_SECOND;
                end
            end
            ST_WAIT_SECOND: begin
                if (click_valid) begin
                    revealed_d[click_idx] = 1'b1;
                    second_idx_d          = click_idx;
                    state_d               = ST_COMPARE;
                end
            end
            ST_COMPARE: begin
                if (sym_arr[first_idx_q] == sym_arr[second_idx_q]) begin
                    matched_d  = matched_q | pair_mask;
                    revealed_d = revealed_q & ~pair_mask;
                    moves_d    = moves_inc;
                    state_d    = (matched_d == {N_CARDS{1'b1}}) ? ST_DONE : ST_WAIT_FIRST;
                end else begin
                    cnt_d   = CNT_W'(HIDE_DELAY - 1);
                    state_d = ST_SHOW;
                end
            end
            ST_SHOW: begin
                if (cnt_q == '0) begin
                    revealed_d = revealed_q & ~pair_mask;
                    moves_d    = moves_inc;
                    state_d    = ST_WAIT_FIRST;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DONE: begin
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Dropping start abandons the game, including any pending hide.
        if (state_q != ST_IDLE && !start) begin
            state_d    = ST_IDLE;
            revealed_d = '0;
            matched_d  = '0;
            moves_d    = '0;
            cnt_d      = '0;
        end

        busy_d     = (state_d == ST_COMPARE) || (state_d == ST_SHOW);
        game_won_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            revealed_q   <= '0;
            matched_q    <= '0;
            moves_q      <= '0;
            busy_q       <= 1'b0;
            game_won_q   <= 1'b0;
            first_idx_q  <= '0;
            second_idx_q <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            revealed_q   <= revealed_d;
            matched_q    <= matched_d;
            moves_q      <= moves_d;
            busy_q       <= busy_d;
            game_won_q   <= game_won_d;
            first_idx_q  <= first_idx_d;
            second_idx_q <= second_idx_d;
            cnt_q        <= cnt_d;
        end
    end

    assign revealed = revealed_q;
    assign matched  = matched_q;
    assign moves    = moves_q;
    assign busy     = busy_q;
    assign game_won = game_won_q;

endmodule

// File: tb/tb_card_pair_controller.sv
// Directed bench for card_pair_controller on a 4-card board (symbols A,B,A,B).
module tb_card_pair_controller;

    localparam int N  = 4;
    localparam int SW = 2;
    localparam int HD = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [N-1:0]  card_event;
    logic [N*SW-1:0] card_symbols;
    logic [N-1:0]  revealed;
    logic [N-1:0]  matched;
    logic [11:0]   moves;
    logic          busy;
    logic          game_won;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    card_pair_controller #(
        .N_CARDS    (N),
        .SYM_W      (SW),
        .HIDE_DELAY (HD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .card_event   (card_event),
        .card_symbols (card_symbols),
        .revealed     (revealed),
        .matched      (matched),
        .moves        (moves),
        .busy         (busy),
        .game_won     (game_won)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One-cycle click level, then released.
    task automatic pulse(input logic [N-1:0] v);
        card_event = v;
        step();
        card_event = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rev"},   32'(revealed), 32'h0);
        check({tag, "_mat"},   32'(matched),  32'h0);
        check({tag, "_moves"}, 32'(moves),    32'h0);
        check({tag, "_busy"},  32'(busy),     32'h0);
        check({tag, "_won"},   32'(game_won), 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        card_symbols = {2'd1, 2'd0, 2'd1, 2'd0};
        rst = 1'b1;
        start = 1'b0;
        card_event = '0;
        step();
        step();
        check_all_zero("reset");
        rst = 1'b0;
        step();
        check_all_zero("idle");

        // Game 1: mismatch with ignored click during SHOW.
        start = 1'b1;
        step();
        pulse(4'b0001);
        check("mm_first", 32'(revealed), 32'h1);
        pulse(4'b0010);
        check("mm_cmp_rev", 32'(revealed), 32'h3);
        check("mm_cmp_busy", 32'(busy), 32'h1);
        for (int i = 0; i < HD; i++) begin
            step();
            if (i == 0) card_event = 4'b1000;
            check("mm_show_rev", 32'(revealed), 32'h3);
            check("mm_show_busy", 32'(busy), 32'h1);
        end
        step();
        check("mm_end_rev", 32'(revealed), 32'h0);
        check("mm_end_busy", 32'(busy), 32'h0);
        check("mm_end_moves", 32'(moves), 32'h1);
        step();
        step();
        check("held_no_click", 32'(revealed), 32'h0);
        card_event = '0;
        step();

        // Level held for 10 cycles gives a single click.
        card_event = 4'b0001;
        for (int i = 0; i < 10; i++) step();
        card_event = '0;
        check("hold_rev", 32'(revealed), 32'h1);
        check("hold_busy", 32'(busy), 32'h0);
        step();
        pulse(4'b0001);
        check("reclick_rev", 32'(revealed), 32'h1);
        check("reclick_busy", 32'(busy), 32'h0);
        pulse(4'b0100);
        check("m_cmp_rev", 32'(revealed), 32'h5);
        step();
        check("m_mat", 32'(matched), 32'h5);
        check("m_rev", 32'(revealed), 32'h0);
        check("m_moves", 32'(moves), 32'h2);
        pulse(4'b0001);
        check("reclick_matched", 32'(revealed), 32'h0);
        pulse(4'b1010);
        check("simul_rev", 32'(revealed), 32'h2);
        step();
        pulse(4'b1000);
        step();
        check("g1_mat", 32'(matched), 32'hf);
        check("g1_won", 32'(game_won), 32'h1);
        check("g1_moves", 32'(moves), 32'h3);
        step();
        check("g1_hold_won", 32'(game_won), 32'h1);
        start = 1'b0;
        step();
        check_all_zero("g1_stop");

        // Game 2: clean win in two moves.
        start = 1'b1;
        step();
        check("g2_clear_moves", 32'(moves), 32'h0);
        pulse(4'b0001);
        pulse(4'b0100);
        step();
        check("g2_mid_won", 32'(game_won), 32'h0);
        pulse(4'b0010);
        pulse(4'b1000);
        step();
        check("win_mat", 32'(matched), 32'hf);
        check("win_rev", 32'(revealed), 32'h0);
        check("win_won", 32'(game_won), 32'h1);
        check("win_moves", 32'(moves), 32'h2);
        start = 1'b0;
        step();
        check_all_zero("win_stop");

        // Reset during the second SHOW cycle.
        start = 1'b1;
        step();
        pulse(4'b0001);
        pulse(4'b0010);
        step();
        step();
        check("rs_show_busy", 32'(busy), 32'h1);
        rst = 1'b1;
        step();
        check_all_zero("rs_after");
        rst = 1'b0;
        step();
        check("rs_re_moves", 32'(moves), 32'h0);
        pulse(4'b0100);
        check("rs_re_click", 32'(revealed), 32'h4);
        start = 1'b0;
        step();
        start = 1'b1;
        step();

        // Saturation of the move counter.
        for (int k = 0; k < 4095; k++) begin
            pulse(4'b0001);
            pulse(4'b0010);
            repeat (HD + 1) step();
        end
        check("sat_reach", 32'(moves), 32'd4095);
        pulse(4'b0001);
        pulse(4'b0010);
        repeat (HD + 1) step();
        check("sat_hold", 32'(moves), 32'd4095);
        check("sat_rev", 32'(revealed), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/card_pair_controller.md
# card_pair_controller

Game-logic stage directly downstream of the per-card click detectors. Consumes the per-card `event_occured` levels (one detector per card), turns them into single click events, and runs the flip-two/compare/hide sequence of the memory game. Produces the face-up and matched card masks for the drawing stage, a move counter and a win flag.

## Interface
Parameters:
- `N_CARDS`, 16: number of cards on the board.
- `SYM_W`, 3: width of one card symbol id.
- `HIDE_DELAY`, 65_000_000: cycles a mismatched pair stays face-up. This is 1 s at 65 MHz. Minimum 1.

Ports:
- `clk`  in  1: system clock.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: game-active level. Low means the game is held in IDLE.
- `card_event`  in  N_CARDS: registered per-card click-inside level. Bit i belongs to card i.
- `card_symbols`  in  N_CARDS*SYM_W: symbol of card i at bits [i*SYM_W +: SYM_W]. Must be stable while `start` is high.
- `revealed`  out  N_CARDS: cards currently face-up and not yet matched.
- `matched`  out  N_CARDS: cards already paired. They stay face-up.
- `moves`  out  12: completed pair attempts. Saturates at 4095.
- `busy`  out  1: high in COMPARE and SHOW. Clicks are ignored while high.
- `game_won`  out  1: high in DONE.

## Operation
- Click extraction:
  - `click = card_event & ~card_event_q`, where `card_event_q` is the previous-cycle register. Only rising edges count.
  - If several bits rise in the same cycle, the lowest index wins. The others are discarded.
  - A click is *valid* only on a card with `revealed[i]==0` and `matched[i]==0`.
- States: IDLE, WAIT_FIRST, WAIT_SECOND, COMPARE, SHOW, DONE.
- IDLE:
  - All outputs are 0.
  - When `start` is 1: go to WAIT_FIRST. `revealed`, `matched` and `moves` are cleared.
- WAIT_FIRST:
  - On a valid click on card i: set `revealed[i]`, latch `first_idx=i`, go to WAIT_SECOND.
- WAIT_SECOND:
  - On a valid click on card j: set `revealed[j]`, latch `second_idx=j`, go to COMPARE.
  - A click on `first_idx` is invalid because that card is already revealed.
- COMPARE (one cycle): compare the symbols of `first_idx` and `second_idx`.
  - Equal: set both `matched` bits, clear both `revealed` bits, `moves+1`. If `matched` becomes all-ones go to DONE, otherwise go to WAIT_FIRST.
  - Different: load the delay counter with HIDE_DELAY-1 and go to SHOW.
- SHOW:
  - The counter decrements each cycle.
  - In the cycle the counter is 0: clear both `revealed` bits, `moves+1`, go to WAIT_FIRST.
- DONE: hold all outputs until `start` falls.
- `start` low in any state other than IDLE: go to IDLE next cycle and clear all outputs.
- `rst` has priority over everything. It forces IDLE and clears all outputs, `card_event_q`, the counter and the latched indices.
- `card_event_q` keeps updating in every state. A level already held when entering WAIT_FIRST does not produce a click.
- The `moves` increment saturates: at 4095 it holds.

## Timing
- All outputs are registered.
- Click latency: `card_event` rises in cycle t, and `revealed` is set at the edge ending cycle t (visible in t+1).
- Match path: second click in cycle t → COMPARE in t+1 → `matched`/`moves` visible in t+2.
- Mismatch path: second click in cycle t → COMPARE in t+1 → SHOW for HIDE_DELAY cycles (t+2 … t+1+HIDE_DELAY) → `revealed` cleared and `moves` incremented, visible in t+2+HIDE_DELAY.
- `busy` is high exactly in the COMPARE and SHOW cycles.
- `game_won` rises in the cycle after the final COMPARE.
- Reset or `start` low takes effect at the next clock edge. Any in-progress SHOW is abandoned and nothing is counted.

## Structure
- Shared package/header `memory_game_pkg`:
  - state encoding constants;
  - default `N_CARDS`, `SYM_W`, `HIDE_DELAY`;
  - `MOVES_W=12`.
- Sub-module `click_encoder`:
  - edge-detect register plus lowest-index priority encoder;
  - outputs `click_valid` and `click_idx` (clog2(N_CARDS) bits);
  - the validity mask (`revealed|matched`) is an input.
- Top level: FSM, delay counter, index/symbol mux, output registers.

## Test plan
Bench uses N_CARDS=4, SYM_W=2, HIDE_DELAY=4, symbols {0:A, 1:B, 2:A, 3:B}.
- Match: `start`=1, rising edge on card 0 then on card 2 → `revealed`=0101, then `matched`=0101, `revealed`=0000, `moves`=1, two cycles after the second click.
- Mismatch: click card 0 then card 1 → `revealed`=0011 and `busy`=1 for 5 cycles, then `revealed`=0000, `moves`=1. A click on card 3 during SHOW is ignored.
- Invalid and simultaneous clicks:
  - `card_event` held high for 10 cycles yields one click only;
  - re-clicking a revealed or matched card changes nothing;
  - `card_event`=1010 rising together selects card 1 only.
- Win: match 0/2 then 1/3 → `matched`=1111, `game_won`=1, `moves`=2. Dropping `start` clears everything the next cycle.
- Reset mid-SHOW: assert `rst` in the 2nd SHOW cycle → next cycle all outputs are 0 and the state is IDLE. With `start` high the block re-enters WAIT_FIRST with `moves`=0.
- Saturation: preload `moves` to 4095 via repeated mismatches (or force), then perform one more attempt → `moves` stays 4095.
